// File: rtl/line_buffer_3x3_if.sv
// Pixel stream in / 3x3 window out bundle for the Sobel front-end line buffer.
// The producer/checker side uses master; the line buffer itself uses slave.
interface line_buffer_3x3_if;
    logic [7:0] pixel_in;
    logic       pixel_valid;
    logic       sof;
    logic [7:0] pixel_out1, pixel_out2, pixel_out3;
    logic [7:0] pixel_out4, pixel_out5, pixel_out6;
    logic [7:0] pixel_out7, pixel_out8, pixel_out9;
    logic       window_valid;
    logic       window_last;

    modport master (
        output pixel_in, pixel_valid, sof,
        input  pixel_out1, pixel_out2, pixel_out3,
               pixel_out4, pixel_out5, pixel_out6,
               pixel_out7, pixel_out8, pixel_out9,
               window_valid, window_last
    );

    modport slave (
        input  pixel_in, pixel_valid, sof,
        output pixel_out1, pixel_out2, pixel_out3,
               pixel_out4, pixel_out5, pixel_out6,
               pixel_out7, pixel_out8, pixel_out9,
               window_valid, window_last
    );
endinterface

// File: rtl/line_buffer_3x3.sv
// Two-line buffer producing a registered 3x3 raster neighbourhood; only windows
// lying fully inside the image are flagged valid.
module line_buffer_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input logic               clk,
    input logic               rst,
    line_buffer_3x3_if.slave  lb_io
);
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d, c_acc;
    logic [RW-1:0] row_q, row_d, r_acc;
    logic [7:0]    lb0_q [IMG_WIDTH];
    logic [7:0]    lb1_q [IMG_WIDTH];
    logic [7:0]    win_q [9];
    logic [7:0]    win_d [9];
    logic [7:0]    top, mid, bot;
    logic          valid_q, valid_d, last_q, last_d;
    logic          accept;

    // A pixel presented during reset is dropped, so it must not touch the line memories.
    assign accept = lb_io.pixel_valid & rst;
    assign c_acc  = lb_io.sof ? '0 : col_q;
    assign r_acc  = lb_io.sof ? '0 : row_q;
    assign top    = lb1_q[c_acc];
    assign mid    = lb0_q[c_acc];
    assign bot    = lb_io.pixel_in;

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (accept) begin
            if (c_acc != COL_MAX) begin
                col_d = c_acc + 1'b1;
                row_d = r_acc;
            end else begin
                col_d = '0;
                row_d = (r_acc == ROW_MAX) ? '0 : r_acc + 1'b1;
            end
            win_d[0] = win_q[1];  win_d[1] = win_q[2];  win_d[2] = top;
            win_d[3] = win_q[4];  win_d[4] = win_q[5];  win_d[5] = mid;
            win_d[6] = win_q[7];  win_d[7] = win_q[8];  win_d[8] = bot;
            valid_d = (r_acc >= RW'(2)) && (c_acc >= CW'(2));
            last_d  = (r_acc == ROW_MAX) && (c_acc == COL_MAX);
        end
    end

    // Line memories carry no reset; stale contents are masked by the validity gating.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[c_acc] <= lb0_q[c_acc];
            lb0_q[c_acc] <= lb_io.pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '{default: '0};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign lb_io.pixel_out1   = win_q[0];
    assign lb_io.pixel_out2   = win_q[1];
    assign lb_io.pixel_out3   = win_q[2];
    assign lb_io.pixel_out4   = win_q[3];
    assign lb_io.pixel_out5   = win_q[4];
    assign lb_io.pixel_out6   = win_q[5];
    assign lb_io.pixel_out7   = win_q[6];
    assign lb_io.pixel_out8   = win_q[7];
    assign lb_io.pixel_out9   = win_q[8];
    assign lb_io.window_valid = valid_q;
    assign lb_io.window_last  = last_q;
endmodule

// File: doc/line_buffer_3x3.md
# line_buffer_3x3

Upstream neighbour of the Sobel edge detector. Accepts a raster-ordered 8-bit grayscale pixel stream, stores the two previous image lines in on-chip line memories, and presents a registered 3x3 neighbourhood (`pixel_out1`..`pixel_out9`) with a `window_valid` qualifier. Only windows that lie fully inside the image are flagged valid, so the edge detector never sees border garbage.

## Interface
- `IMG_WIDTH`, 640, pixels per line (≥3)
- `IMG_HEIGHT`, 480, lines per frame (≥3)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `pixel_in`  in  8  input pixel, raster order
- `pixel_valid`  in  1  `pixel_in` accepted this cycle when 1
- `sof`  in  1  start of frame; qualifies the accepted pixel as (row 0, col 0)
- `pixel_out1`..`pixel_out9`  out  8 each  window, row-major: 1-3 top (oldest) row, 4-6 middle, 7-9 bottom (newest); 1/4/7 leftmost column
- `window_valid`  out  1  window holds a complete in-image neighbourhood
- `window_last`  out  1  qualifies the final valid window of a frame

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1); width `$clog2` of the range. They advance only on accept (`pixel_valid`=1).
- Accepted pixel position (r,c):
  - (0,0) if `sof`=1;
  - otherwise the current counter values.
- After an accept at (r,c), the next position is:
  - c+1, if c < IMG_WIDTH-1;
  - else col wraps to 0 and row increments;
  - at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
- `sof` without `pixel_valid` is ignored.
- Two line memories, IMG_WIDTH x 8 each: `lb0` holds the previous line, `lb1` the line before it.
  - On accept, read `top`=`lb1[c]` and `mid`=`lb0[c]` first.
  - Then write `lb1[c]`<=`lb0[c]` and `lb0[c]`<=`pixel_in`.
  - `bot`=`pixel_in`.
- Window shift on accept:
  - out1<=out2, out2<=out3, out3<=top
  - out4<=out5, out5<=out6, out6<=mid
  - out7<=out8, out8<=out9, out9<=bot
- The window then covers rows r-2..r and columns c-2..c; the centre pixel is (r-1, c-1).
- Output flags:
  - On accept: `window_valid`<=(r≥2 && c≥2); `window_last`<=(r==IMG_HEIGHT-1 && c==IMG_WIDTH-1).
  - No accept: both flags <=0 and the window registers hold.
- Windows spanning a line wrap (c<2) are never flagged valid.
- Line memory contents are never reset. Stale data is harmless because the validity gating excludes it.

## Timing
- Reset (`rst`=0 at a clock edge):
  - col, row, `window_valid`, `window_last` and all `pixel_outN` <=0;
  - any `pixel_valid` in that cycle is dropped.
- Latency: 1 cycle. A window completed by the pixel accepted at edge N is presented, with `window_valid`=1, after edge N.
- One window per accepted pixel once r≥2 and c≥2, giving (IMG_WIDTH-2)*(IMG_HEIGHT-2) valid windows per frame.
- No backpressure; throughput is 1 pixel/cycle.
- Gaps in `pixel_valid` stall all state and deassert the flags; results are otherwise identical to a gapless stream.
- Reset mid-frame: the next accepted pixel is (0,0) even without `sof`. No valid window until position (2,2) of the new stream.
- `sof` mid-frame: the frame aborts and the counters restart at (0,0). The aborted frame gets no `window_last`.
- Back-to-back frames need no idle cycle. The wrap after the last pixel matches `sof` on the next pixel.

## Test plan
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=6, pixel value 8r+c.

1. **Reset:** hold `rst`=0 for 3 cycles with random inputs -> all outputs 0; `window_valid`=`window_last`=0.
2. **Continuous frame with `sof` on the first pixel:**
   - First `window_valid` is the cycle after accepting (2,2), with out1..9 = 0,1,2,8,9,10,16,17,18.
   - Exactly 24 valid windows.
   - The last window has out9=47 and `window_last`=1.
3. **Same frame, random 0-3-cycle `pixel_valid` gaps:** the same 24 windows in the same order. Flags are 0 in gap cycles and `pixel_outN` hold their values.
4. **Abort with `sof`:** stream 20 pixels, then assert `sof` with a new frame -> no `window_valid` until new (2,2); no `window_last` for the aborted frame.
5. **Reset mid-frame:** pulse `rst`=0 for 1 cycle during row 3, then stream a full frame without `sof` -> 24 valid windows matching scenario 2.
6. **Two back-to-back frames, no idle cycle, `sof` only on the first:** 48 valid windows; `window_last` asserted exactly twice.
